acc_core: RTL

ACC_CORE -- requirements
Module: acc_core

---
 rtl/acc_pkg.sv | 30 +++
 rtl/acc_alu.sv | 37 +++
 rtl/acc_core.sv | 96 +++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator core: widths, opcodes and FSM states.
package acc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_JMP   = 3'b101,
        OP_JZ    = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Instructions that read a data operand through the second RAM read port.
    function automatic logic uses_operand(opcode_t op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: computes the next accumulator and carry for one opcode.
module acc_alu
    import acc_pkg::*;
(
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] op_data,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] wide;

    // Opcodes that do not touch the accumulator pass acc and carry through.
    always_comb begin
        wide      = '0;
        result    = acc;
        carry_out = carry_in;
        case (opcode_t'(opcode))
            OP_LOAD: result = op_data;
            OP_ADD: begin
                wide      = {1'b0, acc} + {1'b0, op_data};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            OP_SUB: begin
                wide      = {1'b0, acc} - {1'b0, op_data};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            OP_AND: result = acc & op_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_core.sv
// Two-cycle-per-instruction accumulator CPU driving an external 32x8 RAM
// with two combinational read ports and one synchronous write port.
module acc_core
    import acc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 5'd0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              instr_re,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr_data,
    output logic              op_re,
    output logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              halted
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    opcode_t           opcode;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [ADDR_W-1:0] pc_seq;

    assign opcode = opcode_t'(ir[7:5]);
    assign pc_seq = pc + 1'b1;

    // RAM-facing signals decode straight from state so reset kills them at once.
    assign instr_re   = (state == ST_FETCH);
    assign instr_addr = pc;
    assign op_re      = (state == ST_EXEC) && uses_operand(opcode);
    assign op_addr    = ir[4:0];
    assign mem_we     = (state == ST_EXEC) && (opcode == OP_STORE);
    assign mem_waddr  = ir[4:0];
    assign mem_wdata  = acc;

    acc_alu u_alu (
        .opcode    (ir[7:5]),
        .acc       (acc),
        .op_data   (op_data),
        .carry_in  (carry),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            acc    <= '0;
            ir     <= '0;
            carry  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    ir    <= instr_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    acc   <= alu_result;
                    carry <= alu_carry;
                    pc    <= pc_seq;
                    state <= ST_FETCH;
                    // Control-flow opcodes override the sequential pc and next state.
                    case (opcode)
                        OP_JMP: pc <= ir[4:0];
                        OP_JZ: begin
                            if (acc == '0) pc <= ir[4:0];
                        end
                        OP_HALT: begin
                            pc     <= pc;
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
